requant_relu: RTL
=================

REQUANT_RELU -- requirements
Module: requant_relu

Interface
REQ-001 Parameter MAP_WIDTH, default 28: conv output map width and height, in pixels.
REQ-002 Parameter ACC_W, default 32: width of the signed conv accumulator.
REQ-003 Parameter M_W, default 16: width of the unsigned requant multiplier.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 valid_in  input  1  acc_in is valid this cycle; no backpressure.
REQ-007 acc_in  input  ACC_W signed  conv accumulator for one output pixel, raster order.
REQ-008 cfg_load  input  1  single-cycle request to latch cfg_bias, cfg_mult, cfg_shift, cfg_relu.
REQ-009 cfg_bias  input  ACC_W signed  per-map bias.
REQ-010 cfg_mult  input  M_W unsigned  requant multiplier.
REQ-011 cfg_shift  input  6  right-shift amount.
REQ-012 cfg_relu  input  1  ReLU enable.
REQ-013 valid_out  output  1  pixel_out valid; drives maxpool valid_in.
REQ-014 pixel_out  output  8 signed  requantized pixel.
REQ-015 map_done  output  1  one-cycle pulse coincident with the last valid_out of a map.
REQ-016 cfg_err  output  1  sticky: cfg_load was rejected.
REQ-017 sat_count  output  16  number of outputs clipped by saturation.

Function
REQ-018 Shadow config registers shall load on cfg_load only when the block is idle: in_count == 0 and no valid data in any pipeline stage.
REQ-019 A non-idle cfg_load shall be ignored, set cfg_err, and leave the shadow registers unchanged.
REQ-020 in_count shall count accepted valid_in pixels modulo MAP_WIDTH*MAP_WIDTH.
REQ-021 Stage 1 shall register sum = acc_in + bias at ACC_W+1 bits, so it never overflows.
REQ-022 Stage 2 shall register prod = sum * mult, full-precision signed, at ACC_W+M_W+2 bits, with mult zero-extended.
REQ-023 Stage 3 rounding: if shift == 0, r = prod; otherwise r = (prod + 2^(shift-1)) >>> shift, an arithmetic shift (round half toward +inf).
REQ-024 Effective shift = min(cfg_shift, 31).
REQ-025 Saturation: r > 127 gives 127; r < -128 gives -128; either case flags sat.
REQ-026 ReLU: when relu is set and the saturated value is < 0, the output shall be 0.
REQ-027 ReLU is applied after saturation, so a value clipped to -128 by saturation and then zeroed by ReLU still counts as sat.
REQ-028 Latency shall be exactly 3 cycles: valid_in at cycle t gives valid_out at t+3.
REQ-029 Gaps in valid_in shall be preserved one-for-one in valid_out, with full throughput of 1 pixel/cycle.
REQ-030 pixel_out shall hold its last value when valid_out = 0.
REQ-031 out_count shall count valid_out beats modulo MAP_WIDTH*MAP_WIDTH.
REQ-032 map_done shall assert on the beat where out_count == MAP_WIDTH*MAP_WIDTH-1; out_count then wraps to 0.
REQ-033 Back-to-back maps shall stream with no bubble.
REQ-034 sat_count shall increment once per flagged valid_out beat and saturate at 16'hFFFF (no wrap).
REQ-035 sat_count shall not clear on map boundaries.

Reset
REQ-036 On rst, valid_out, pixel_out, map_done, cfg_err, sat_count, in_count, out_count and all pipeline valid bits shall reset to 0.
REQ-037 On rst, the shadow config shall reset to bias 0, mult 1, shift 0, relu 1.
REQ-038 rst mid-map shall discard all in-flight pixels: no valid_out in the cycle after rst is released.
REQ-039 rst has priority over valid_in and cfg_load in the same cycle.

Verification
REQ-040 Reset defaults, then acc_in = 5, 200, -7 on consecutive cycles -> pixel_out 5, 127, 0 at t+3..t+5; sat_count = 1.
REQ-041 cfg bias = 10, mult = 3, shift = 2, relu = 0; acc_in = 1 -> (11*3 + 2) >>> 2 = 8.
REQ-042 With the REQ-041 config, acc_in = -15 -> (-15 + 10)*3 = -15, (-15 + 2) >>> 2 = -4.
REQ-043 Stream 784 pixels with MAP_WIDTH = 28, gap-free, immediately followed by 3 more -> map_done pulses exactly once, on output beat 784; beats 785-787 start the next map.
REQ-044 Valid pattern 1,0,1,1,0 -> valid_out shows 1,0,1,1,0 delayed 3 cycles.
REQ-045 cfg_load at pixel 100 of a map -> cfg_err = 1 and outputs unchanged; cfg_load after map_done with the pipeline drained -> accepted.
REQ-046 Force 70000 saturating pixels -> sat_count holds at 65535.
REQ-047 rst asserted with 2 pixels in flight -> no valid_out afterwards; the next map's map_done arrives after 784 fresh pixels.

Source files
------------

// File: rtl/requant_relu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// requant_relu : bias + multiply + round/shift + saturate + ReLU, 3-cycle pipe
// Revision     : 1.0
// ---------------------------------------------------------------------------
module requant_relu #(
  parameter int MAP_WIDTH = 28,
  parameter int ACC_W     = 32,
  parameter int M_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    cfg_load,
  input  logic signed [ACC_W-1:0] cfg_bias,
  input  logic [M_W-1:0]          cfg_mult,
  input  logic [5:0]              cfg_shift,
  input  logic                    cfg_relu,
  output logic                    valid_out,
  output logic signed [7:0]       pixel_out,
  output logic                    map_done,
  output logic                    cfg_err,
  output logic [15:0]             sat_count
);

  localparam int C_PIX = MAP_WIDTH * MAP_WIDTH;
  localparam int C_CW  = (C_PIX > 1) ? $clog2(C_PIX) : 1;
  localparam int C_PW  = ACC_W + M_W + 2;
  localparam logic [C_CW-1:0]        C_LAST = C_CW'(C_PIX - 1);
  localparam logic signed [C_PW-1:0] C_HI   = C_PW'(127);
  localparam logic signed [C_PW-1:0] C_LO   = C_PW'(-128);

  logic signed [ACC_W-1:0] r_bias;
  logic [M_W-1:0]          r_mult;
  logic [4:0]              r_shift;
  logic                    r_relu;
  logic [C_CW-1:0]         r_in_count;
  logic [C_CW-1:0]         r_out_count;
  logic                    r_s1_valid;
  logic signed [ACC_W:0]   r_s1_sum;
  logic                    r_s2_valid;
  logic signed [C_PW-1:0]  r_s2_prod;

  logic                    w_idle;
  logic signed [ACC_W:0]   w_sum;
  logic signed [C_PW-1:0]  w_sum_ext;
  logic signed [C_PW-1:0]  w_mult_ext;
  logic signed [C_PW-1:0]  w_rnd;
  logic signed [C_PW-1:0]  w_rsum;
  logic signed [C_PW-1:0]  w_r;
  logic                    w_sat;
  logic signed [7:0]       w_clip;
  logic signed [7:0]       w_pix;

  // A pixel arriving this cycle also counts as busy: it would otherwise meet
  // the old bias in stage 1 and the new multiplier in stage 2.
  assign w_idle = (r_in_count == '0) && !r_s1_valid && !r_s2_valid && !valid_out && !valid_in;

  assign w_sum      = {acc_in[ACC_W-1], acc_in} + {r_bias[ACC_W-1], r_bias};
  assign w_sum_ext  = {{(M_W+1){r_s1_sum[ACC_W]}}, r_s1_sum};
  assign w_mult_ext = {{(ACC_W+2){1'b0}}, r_mult};

  assign w_rnd  = (r_shift == 5'd0) ? '0 : (C_PW'(1) << (r_shift - 5'd1));
  assign w_rsum = r_s2_prod + w_rnd;
  assign w_r    = w_rsum >>> r_shift;

  always_comb begin
    w_sat  = 1'b0;
    w_clip = w_r[7:0];
    if (w_r > C_HI) begin
      w_sat  = 1'b1;
      w_clip = 8'sd127;
    end else if (w_r < C_LO) begin
      w_sat  = 1'b1;
      w_clip = -8'sd128;
    end
    w_pix = (r_relu && w_clip[7]) ? 8'sd0 : w_clip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bias  <= '0;
      r_mult  <= M_W'(1);
      r_shift <= 5'd0;
      r_relu  <= 1'b1;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      if (w_idle) begin
        r_bias  <= cfg_bias;
        r_mult  <= cfg_mult;
        r_shift <= cfg_shift[5] ? 5'd31 : cfg_shift[4:0];
        r_relu  <= cfg_relu;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_count <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= valid_in;
      r_s2_valid <= r_s1_valid;
      if (valid_in)
        r_in_count <= (r_in_count == C_LAST) ? '0 : r_in_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_s1_sum  <= w_sum;
    r_s2_prod <= w_sum_ext * w_mult_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      pixel_out   <= '0;
      map_done    <= 1'b0;
      sat_count   <= '0;
      r_out_count <= '0;
    end else begin
      valid_out <= r_s2_valid;
      map_done  <= r_s2_valid && (r_out_count == C_LAST);
      if (r_s2_valid) begin
        pixel_out   <= w_pix;
        r_out_count <= (r_out_count == C_LAST) ? '0 : r_out_count + 1'b1;
        if (w_sat && (sat_count != 16'hFFFF))
          sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
